// File: rtl/redirect_ctrl_pkg.sv
// Shared types for the execute-stage redirect controller: FSM and source encodings,
// the arbiter winner record and small target helpers.
package redirect_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int FCNT_W = 4;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        RDR_IDLE     = 2'd0,
        RDR_REDIRECT = 2'd1,
        RDR_FLUSH    = 2'd2
    } rdr_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_TRAP = 2'd1,
        SRC_JMP  = 2'd2,
        SRC_BR   = 2'd3
    } rdr_src_e;

    typedef struct packed {
        logic     vld;
        rdr_src_e src;
        addr_t    tgt;
    } arb_win_t;

    // Trap vectors come from CSR state and are trusted; only jump/branch targets are checked.
    function automatic logic tgt_misaligned(input rdr_src_e src, input addr_t tgt);
        return (src != SRC_TRAP) && tgt[1];
    endfunction

    function automatic addr_t tgt_align(input addr_t tgt);
        return {tgt[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/redirect_ctrl_if.sv
// Request inputs from trap/jump/branch units and the registered redirect/squash outputs.
// master = redirect controller side, slave = pipeline/fetch side.
interface redirect_ctrl_if #(
    parameter int CNT_W = 32
);
    import redirect_ctrl_pkg::*;

    logic             trap_req;
    addr_t            trap_vec;
    logic             jmp_req;
    addr_t            jmp_target;
    logic             br_req;
    addr_t            br_target;
    logic             redir_valid;
    addr_t            redir_target;
    logic             redir_ready;
    logic             flush;
    logic             busy;
    logic             misalign_err;
    logic [CNT_W-1:0] redir_count;

    modport master (
        input  trap_req, trap_vec, jmp_req, jmp_target, br_req, br_target, redir_ready,
        output redir_valid, redir_target, flush, busy, misalign_err, redir_count
    );

    modport slave (
        output trap_req, trap_vec, jmp_req, jmp_target, br_req, br_target, redir_ready,
        input  redir_valid, redir_target, flush, busy, misalign_err, redir_count
    );

endinterface

// File: rtl/redirect_arb.sv
// Combinational fixed-priority select of redirect sources (trap > jmp > br).
// Zero latency; losers are dropped, there is no queueing.
module redirect_arb
    import redirect_ctrl_pkg::*;
(
    input  logic     trap_req,
    input  addr_t    trap_vec,
    input  logic     jmp_req,
    input  addr_t    jmp_target,
    input  logic     br_req,
    input  addr_t    br_target,
    output arb_win_t win
);

    always_comb begin
        win.vld = 1'b0;
        win.src = SRC_NONE;
        win.tgt = '0;
        if (trap_req) begin
            win.vld = 1'b1;
            win.src = SRC_TRAP;
            win.tgt = trap_vec;
        end else if (jmp_req) begin
            win.vld = 1'b1;
            win.src = SRC_JMP;
            win.tgt = jmp_target;
        end else if (br_req) begin
            win.vld = 1'b1;
            win.src = SRC_BR;
            win.tgt = br_target;
        end
    end

endmodule

// File: rtl/redirect_ctrl.sv
// PC-redirect controller: arbitrates trap/jmp/br, holds one registered target for fetch,
// then squashes for FLUSH_CYCLES. Outputs appear one cycle after the request; target held until ready.
module redirect_ctrl
    import redirect_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    redirect_ctrl_if.master  rif
);

    localparam logic [FCNT_W-1:0] FLUSH_LD = FCNT_W'(FLUSH_CYCLES);

    rdr_state_e        state_q, state_d;
    addr_t             tgt_q, tgt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mis_q, mis_d;

    arb_win_t win;
    logic     win_mis;
    logic     accept;

    redirect_arb u_arb (
        .trap_req   (rif.trap_req),
        .trap_vec   (rif.trap_vec),
        .jmp_req    (rif.jmp_req),
        .jmp_target (rif.jmp_target),
        .br_req     (rif.br_req),
        .br_target  (rif.br_target),
        .win        (win)
    );

    assign win_mis = win.vld && tgt_misaligned(win.src, win.tgt);
    assign accept  = (state_q == RDR_REDIRECT) && rif.redir_ready;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= RDR_IDLE;
            tgt_q   <= '0;
            fcnt_q  <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RDR_IDLE: begin
                if (win.vld && !win_mis) state_d = RDR_REDIRECT;
            end
            RDR_REDIRECT: begin
                if (accept) state_d = (FLUSH_CYCLES == 0) ? RDR_IDLE : RDR_FLUSH;
            end
            RDR_FLUSH: begin
                // A trap from an older instruction beats the rest of the squash window.
                if (rif.trap_req)               state_d = RDR_REDIRECT;
                else if (fcnt_q <= FCNT_W'(1)) state_d = RDR_IDLE;
            end
            default: state_d = RDR_IDLE;
        endcase
    end

    always_comb begin
        tgt_d  = tgt_q;
        fcnt_d = fcnt_q;
        cnt_d  = cnt_q;
        mis_d  = 1'b0;
        unique case (state_q)
            RDR_IDLE: begin
                if (win_mis)      mis_d = 1'b1;
                else if (win.vld) tgt_d = tgt_align(win.tgt);
            end
            RDR_REDIRECT: begin
                if (accept) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    fcnt_d = FLUSH_LD;
                end
            end
            RDR_FLUSH: begin
                if (rif.trap_req) begin
                    tgt_d  = tgt_align(rif.trap_vec);
                    fcnt_d = '0;
                end else begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                end
            end
            default: fcnt_d = '0;
        endcase
    end

    always_comb begin
        rif.redir_valid  = (state_q == RDR_REDIRECT);
        rif.flush        = (state_q != RDR_IDLE);
        rif.busy         = (state_q != RDR_IDLE);
        rif.redir_target = tgt_q;
        rif.misalign_err = mis_q;
        rif.redir_count  = cnt_q;
    end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: directed scenarios followed by random traffic, checked by a scoreboard.
module tb_redirect_ctrl;
    import redirect_ctrl_pkg::*;

    localparam int FC = 2;
    localparam int CW = 32;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    redirect_ctrl_if #(.CNT_W(CW)) rif ();

    redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .rif   (rif)
    );

    typedef struct {
        bit          vld;
        bit          fl;
        bit          bsy;
        bit          mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] tgt_q[$];

    // Reference model: one outstanding offer, a count of squash cycles still owed.
    bit          m_offer;
    int          m_sq;
    bit          m_mis;
    logic [31:0] m_cnt;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_offer = 1'b0;
        m_sq    = 0;
        m_mis   = 1'b0;
        m_cnt   = '0;
        exp_q.delete();
        tgt_q.delete();
    endtask

    task automatic offer(input logic [31:0] t);
        tgt_q.push_back(t & 32'hFFFF_FFFE);
        m_offer = 1'b1;
    endtask

    // Record what this cycle must show, then advance the model with the inputs now applied.
    task automatic push_and_step();
        exp_t e;
        e.vld = m_offer;
        e.fl  = m_offer || (m_sq > 0);
        e.bsy = e.fl;
        e.mis = m_mis;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        m_mis = 1'b0;
        if (m_offer) begin
            if (rif.redir_ready) begin
                m_cnt   = m_cnt + 32'd1;
                m_offer = 1'b0;
                m_sq    = FC;
            end
        end else if (m_sq > 0) begin
            if (rif.trap_req) begin
                offer(rif.trap_vec);
                m_sq = 0;
            end else begin
                m_sq = m_sq - 1;
            end
        end else if (rif.trap_req) begin
            offer(rif.trap_vec);
        end else if (rif.jmp_req) begin
            if (rif.jmp_target[1]) m_mis = 1'b1;
            else                   offer(rif.jmp_target);
        end else if (rif.br_req) begin
            if (rif.br_target[1]) m_mis = 1'b1;
            else                  offer(rif.br_target);
        end
    endtask

    task automatic set_inputs(input bit tr, input logic [31:0] tv, input bit j, input logic [31:0] jt,
                              input bit b, input logic [31:0] bt, input bit rdy);
        rif.trap_req    = tr;
        rif.trap_vec    = tv;
        rif.jmp_req     = j;
        rif.jmp_target  = jt;
        rif.br_req      = b;
        rif.br_target   = bt;
        rif.redir_ready = rdy;
    endtask

    task automatic drive(input bit tr, input logic [31:0] tv, input bit j, input logic [31:0] jt,
                         input bit b, input logic [31:0] bt, input bit rdy);
        @(posedge i_clk);
        #2;
        set_inputs(tr, tv, j, jt, b, bt, rdy);
        push_and_step();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) drive(0, 32'h0, 0, 32'h0, 0, 32'h0, rdy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_redir_valid"},  rif.redir_valid, 0);
        check({tag, "_redir_target"}, rif.redir_target, 0);
        check({tag, "_flush"},        rif.flush, 0);
        check({tag, "_busy"},         rif.busy, 0);
        check({tag, "_misalign_err"}, rif.misalign_err, 0);
        check({tag, "_redir_count"},  rif.redir_count, 0);
    endtask

    task automatic release_reset();
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        set_inputs(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        push_and_step();
        mon_en = 1'b1;
    endtask

    // Monitor: compares every cycle's outputs and any presented target against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_underflow: got no expectation for cycle at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("redir_valid",  rif.redir_valid, e.vld);
                    check("flush",        rif.flush, e.fl);
                    check("busy",         rif.busy, e.bsy);
                    check("misalign_err", rif.misalign_err, e.mis);
                    check("redir_count",  rif.redir_count, e.cnt);
                    if (rif.redir_valid) begin
                        if (tgt_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_redirect: got target %h, expected none at %0t",
                                     rif.redir_target, $time);
                        end else begin
                            check("redir_target", rif.redir_target, tgt_q[0]);
                            if (rif.redir_ready) void'(tgt_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit          tr, j, b, rdy;
        logic [31:0] tv, jt, bt;

        set_inputs(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        m_reset();
        repeat (3) @(posedge i_clk);
        #2;
        check_reset_outputs("por");
        release_reset();

        // Basic jump, accepted one cycle after it is presented.
        drive(0, 32'h0, 1, 32'h0000_0100, 0, 32'h0, 0);
        idle(1, 1);
        idle(4, 0);

        // All three sources together: only the trap vector is honoured.
        drive(1, 32'h0000_0080, 1, 32'h0000_0200, 1, 32'h0000_0300, 0);
        idle(6, 1);

        // Misaligned branch: error pulse, no redirect.
        drive(0, 32'h0, 0, 32'h0, 1, 32'h0000_0102, 0);
        idle(3, 0);

        // Lower-priority misaligned target under a valid jump: no error.
        drive(0, 32'h0, 1, 32'h0000_0120, 1, 32'h0000_0302, 0);
        idle(1, 1);
        idle(3, 0);

        // Misaligned trap vector is accepted; bit0 cleared.
        drive(1, 32'h0000_0047, 0, 32'h0, 0, 32'h0, 0);
        idle(1, 1);
        idle(3, 0);

        // Fetch stalls for five cycles.
        drive(0, 32'h0, 1, 32'h0000_0400, 0, 32'h0, 0);
        idle(5, 0);
        idle(1, 1);
        idle(4, 0);

        // Jump during the squash window is dropped; a trap relatches.
        drive(0, 32'h0, 1, 32'h0000_0500, 0, 32'h0, 0);
        idle(1, 1);
        drive(0, 32'h0, 1, 32'h0000_0600, 0, 32'h0, 0);
        drive(1, 32'h0000_0040, 0, 32'h0, 0, 32'h0, 0);
        idle(1, 1);
        idle(4, 0);

        // Back-to-back: request on the first idle cycle after the window closes.
        drive(0, 32'h0, 0, 32'h0, 1, 32'h0000_0700, 0);
        idle(1, 1);
        idle(FC, 0);
        drive(0, 32'h0, 0, 32'h0, 1, 32'h0000_0704, 1);
        idle(4, 1);

        // Reset while a redirect is being offered.
        drive(0, 32'h0, 1, 32'h0000_0900, 0, 32'h0, 0);
        idle(1, 0);
        #1;
        mon_en = 1'b0;
        i_rst  = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_reset();
        release_reset();
        drive(0, 32'h0, 0, 32'h0, 1, 32'h0000_0a00, 0);
        idle(1, 1);
        idle(4, 0);

        for (int n = 0; n < 1500; n++) begin
            tr  = ($urandom_range(0, 99) < 10);
            j   = ($urandom_range(0, 99) < 30);
            b   = ($urandom_range(0, 99) < 30);
            rdy = ($urandom_range(0, 99) < 50);
            tv  = $urandom;
            jt  = $urandom;
            bt  = $urandom;
            drive(tr, tv, j, jt, b, bt, rdy);
        end

        idle(10, 1);
        @(negedge i_clk);
        #1;
        check("targets_drained", 32'(tgt_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
